instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit_pkg.sv | 18 +
 rtl/instr_fetch_unit_branch_target_calc.sv | 19 +
 rtl/instr_fetch_unit.sv | 86 ++++++++
 tb/tb_instr_fetch_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: state encoding, NOP, PC increment and the
// opcode constants also used by immediateG and the decoder.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int unsigned PC_INCR = 4;

  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;

endpackage

// File: rtl/instr_fetch_unit_branch_target_calc.sv
// Combinational branch target: pc + sign_extend(imm) * 2, plus a flag when
// the result is not word aligned. Shared with the execute stage.
module branch_target_calc #(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] branch_pc,
  input  logic [11:0]         branch_imm,
  output logic [PC_WIDTH-1:0] target,
  output logic                misaligned
);

  logic [PC_WIDTH-1:0] offset;

  // Immediate is in halfword units, so append one zero after sign extension.
  assign offset     = {{(PC_WIDTH-13){branch_imm[11]}}, branch_imm, 1'b0};
  assign target     = branch_pc + offset;
  assign misaligned = target[1];

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32 fetch stage: PC, word fetch over a req/ready handshake, one-entry
// instruction register with valid/stall flow control, and branch redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_pc,
  input  logic [11:0]         branch_imm,
  output logic [31:0]         instr_out,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  output logic                misaligned_err
);

  fetch_state_t        state, state_next;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] target;
  logic                target_misaligned;
  logic                redirect;
  logic                transfer;
  logic                consume;

  branch_target_calc #(.PC_WIDTH(PC_WIDTH)) u_btc (
    .branch_pc  (branch_pc),
    .branch_imm (branch_imm),
    .target     (target),
    .misaligned (target_misaligned)
  );

  assign imem_addr = pc;
  assign redirect  = (state == ST_FETCH) && branch_taken;
  assign transfer  = imem_req && imem_ready;
  assign consume   = instr_valid && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      ST_BOOT:  state_next = ST_FETCH;
      ST_FETCH: begin
        // A redirect cycle never fetches; the target is requested next cycle.
        imem_req = (!instr_valid || !stall) && !branch_taken;
        if (branch_taken && target_misaligned) state_next = ST_HALT;
      end
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      instr_out      <= NOP;
      instr_pc       <= '0;
      instr_valid    <= 1'b0;
      misaligned_err <= 1'b0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
      if (target_misaligned) misaligned_err <= 1'b1;
      else                   pc             <= target;
    end else if (transfer) begin
      instr_out   <= imem_rdata;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
      pc          <= pc + PC_WIDTH'(PC_INCR);
    end else if (consume) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table with explicit expected
// values, then random stimulus checked against a behavioural model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, imem_req, imem_ready, stall, branch_taken;
  logic        instr_valid, misaligned_err;
  logic [31:0] imem_addr, imem_rdata, branch_pc, instr_out, instr_pc;
  logic [11:0] branch_imm;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_pc(branch_pc), .branch_imm(branch_imm),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .misaligned_err(misaligned_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00A0_0093;
      32'h4:   return 32'h0FF0_0113;
      32'h8:   return 32'h0000_0063;
      default: return a ^ 32'h5A5A_0013;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Behavioural model: 0=boot, 1=fetch, 2=halted
  int          m_st;
  logic [31:0] m_pc, m_out, m_ipc;
  logic        m_valid, m_err;

  function automatic logic m_req();
    return (m_st == 1) && (!m_valid || !stall) && !branch_taken;
  endfunction

  task automatic model_edge();
    int          off;
    logic [31:0] tgt;
    logic        req;
    req = m_req();
    off = branch_imm[11] ? int'(branch_imm) - 4096 : int'(branch_imm);
    tgt = branch_pc + 32'(off * 2);
    if (!rst_n) begin
      m_st = 0; m_pc = 0; m_valid = 0; m_out = 32'h13; m_ipc = 0; m_err = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (branch_taken) begin
        m_valid = 0;
        if (tgt % 4 != 0) begin m_st = 2; m_err = 1; end
        else m_pc = tgt;
      end else if (req && imem_ready) begin
        m_out = mem_word(m_pc); m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 4;
      end else if (m_valid && !stall) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("m_req",   32'(imem_req),       32'(m_req()));
    check("m_addr",  imem_addr,           m_pc);
    check("m_valid", 32'(instr_valid),    32'(m_valid));
    check("m_out",   instr_out,           m_out);
    check("m_ipc",   instr_pc,            m_ipc);
    check("m_err",   32'(misaligned_err), 32'(m_err));
  endtask

  typedef struct {
    logic        rst_n, ready, stall, br;
    logic [31:0] bpc;
    logic [11:0] bimm;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_out, e_ipc;
    logic        e_err;
  } vec_t;

  vec_t vecs[20];

  initial begin
    // rst rdy stl br  bpc      bimm     req addr          vld out            ipc           err
    vecs[0]  = '{1, 1, 0, 0, 32'h0,   12'h0,   0, 32'h0,        0, 32'h13,        32'h0,        0};
    vecs[1]  = '{1, 1, 0, 0, 32'h0,   12'h0,   1, 32'h0,        0, 32'h13,        32'h0,        0};
    vecs[2]  = '{1, 1, 0, 0, 32'h0,   12'h0,   1, 32'h4,        1, 32'h00A00093,  32'h0,        0};
    vecs[3]  = '{1, 1, 0, 0, 32'h0,   12'h0,   1, 32'h8,        1, 32'h0FF00113,  32'h4,        0};
    vecs[4]  = '{1, 0, 0, 0, 32'h0,   12'h0,   1, 32'hC,        1, 32'h00000063,  32'h8,        0};
    vecs[5]  = '{1, 0, 0, 0, 32'h0,   12'h0,   1, 32'hC,        0, 32'h00000063,  32'h8,        0};
    vecs[6]  = '{1, 0, 0, 0, 32'h0,   12'h0,   1, 32'hC,        0, 32'h00000063,  32'h8,        0};
    vecs[7]  = '{1, 1, 0, 0, 32'h0,   12'h0,   1, 32'hC,        0, 32'h00000063,  32'h8,        0};
    vecs[8]  = '{1, 1, 1, 0, 32'h0,   12'h0,   0, 32'h10,       1, 32'h5A5A001F,  32'hC,        0};
    vecs[9]  = '{1, 1, 1, 0, 32'h0,   12'h0,   0, 32'h10,       1, 32'h5A5A001F,  32'hC,        0};
    vecs[10] = '{1, 1, 0, 0, 32'h0,   12'h0,   1, 32'h10,       1, 32'h5A5A001F,  32'hC,        0};
    vecs[11] = '{1, 1, 0, 1, 32'h100, 12'hFFE, 0, 32'h14,       1, 32'h5A5A0003,  32'h10,       0};
    vecs[12] = '{1, 1, 0, 0, 32'h0,   12'h0,   1, 32'hFC,       0, 32'h5A5A0003,  32'h10,       0};
    vecs[13] = '{1, 1, 0, 1, 32'h0,   12'hFFE, 0, 32'h100,      1, 32'h5A5A00EF,  32'hFC,       0};
    vecs[14] = '{1, 1, 0, 0, 32'h0,   12'h0,   1, 32'hFFFFFFFC, 0, 32'h5A5A00EF,  32'hFC,       0};
    vecs[15] = '{1, 0, 0, 0, 32'h0,   12'h0,   1, 32'h0,        1, 32'hA5A5FFEF,  32'hFFFFFFFC, 0};
    vecs[16] = '{1, 1, 0, 1, 32'h0,   12'h001, 0, 32'h0,        0, 32'hA5A5FFEF,  32'hFFFFFFFC, 0};
    vecs[17] = '{1, 1, 0, 1, 32'h100, 12'hFFE, 0, 32'h0,        0, 32'hA5A5FFEF,  32'hFFFFFFFC, 1};
    vecs[18] = '{0, 1, 0, 0, 32'h0,   12'h0,   0, 32'h0,        0, 32'hA5A5FFEF,  32'hFFFFFFFC, 1};
    vecs[19] = '{1, 1, 0, 0, 32'h0,   12'h0,   0, 32'h0,        0, 32'h13,        32'h0,        0};

    rst_n = 0; imem_ready = 0; stall = 0; branch_taken = 0;
    branch_pc = 0; branch_imm = 0;
    m_st = 0; m_pc = 0; m_valid = 0; m_out = 32'h13; m_ipc = 0; m_err = 0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; imem_ready = vecs[i].ready; stall = vecs[i].stall;
      branch_taken = vecs[i].br; branch_pc = vecs[i].bpc; branch_imm = vecs[i].bimm;
      #1;
      check($sformatf("v%0d_req", i),   32'(imem_req),       32'(vecs[i].e_req));
      check($sformatf("v%0d_addr", i),  imem_addr,           vecs[i].e_addr);
      check($sformatf("v%0d_valid", i), 32'(instr_valid),    32'(vecs[i].e_valid));
      check($sformatf("v%0d_out", i),   instr_out,           vecs[i].e_out);
      check($sformatf("v%0d_ipc", i),   instr_pc,            vecs[i].e_ipc);
      check($sformatf("v%0d_err", i),   32'(misaligned_err), 32'(vecs[i].e_err));
      @(posedge clk);
      model_edge();
    end

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst_n        = ($urandom_range(0, 39) != 0);
      imem_ready   = ($urandom_range(0, 3) != 0);
      stall        = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      branch_pc    = {$urandom(), 2'b00} >> 2 << 2;
      branch_imm   = 12'($urandom());
      if ($urandom_range(0, 3) != 0) branch_imm[0] = 1'b0;
      #1;
      check_model();
      @(posedge clk);
      model_edge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
